// File: rtl/md_pkg.sv
// Shared types and sign-control helpers for the iterative multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Bit n set means funct3 value n treats that operand as two's complement.
    localparam logic [7:0] SIGNED_A_OPS = 8'h57;  // MUL MULH MULHSU DIV REM
    localparam logic [7:0] SIGNED_B_OPS = 8'h53;  // MUL MULH DIV REM

    function automatic logic op_signed_a(input md_op_e op);
        return SIGNED_A_OPS[op];
    endfunction

    function automatic logic op_signed_b(input md_op_e op);
        return SIGNED_B_OPS[op];
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem_op(input md_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/md_iter_datapath.sv
// Radix-2 datapath: shift-add multiply or restoring divide, one bit per step.
module md_iter_datapath #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);

    // acc: product high half / partial remainder; shreg: multiplier / quotient bits.
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] shreg;
    logic [XLEN-1:0] operand;
    logic            div_mode;

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        sum     = shreg[0] ? ({1'b0, acc} + {1'b0, operand}) : {1'b0, acc};
        shifted = {acc, shreg[XLEN-1]};
        ge      = shifted >= {1'b0, operand};
        diff    = shifted[XLEN-1:0] - operand;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            shreg    <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= '0;
            shreg    <= is_div ? a_mag : b_mag;
            operand  <= is_div ? b_mag : a_mag;
            div_mode <= is_div;
        end else if (step) begin
            if (div_mode) begin
                acc   <= ge ? diff : shifted[XLEN-1:0];
                shreg <= {shreg[XLEN-2:0], ge};
            end else begin
                acc   <= sum[XLEN:1];
                shreg <= {sum[0], shreg[XLEN-1:1]};
            end
        end
    end

    assign product   = {acc, shreg};
    assign quotient  = shreg;
    assign remainder = acc;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready on both sides.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output md_state_e       state
);

    // Handshake: a request is taken on a rising edge with in_valid && in_ready
    // && !flush; a result is handed off on a rising edge with out_valid &&
    // out_ready. in_ready is only high in IDLE and out_valid only in DONE.

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_next;
    md_op_e          op_in, op_q;
    logic            sa_q, sb_q, bzero_q, last_step;
    logic [CW-1:0]   counter;
    logic            accept, sa_in, sb_in, b_zero, sgn_ovf, early, dp_step;
    logic [XLEN-1:0] a_mag, b_mag, early_result, final_result, quot_s, rem_s;
    logic [XLEN-1:0] quotient, remainder;
    logic [2*XLEN-1:0] product, prod_s;

    assign op_in = md_op_e'(in_op);

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = in_valid && in_ready && !flush;
        dp_step   = (state == CALC) && !last_step;

        sa_in   = op_signed_a(op_in) && in_a[XLEN-1];
        sb_in   = op_signed_b(op_in) && in_b[XLEN-1];
        a_mag   = sa_in ? -in_a : in_a;
        b_mag   = sb_in ? -in_b : in_b;
        b_zero  = (in_b == '0);
        sgn_ovf = op_signed_b(op_in) && is_div_op(op_in) && (in_a == MIN_NEG) && (in_b == '1);
        early   = EARLY_OUT && is_div_op(op_in) && (b_zero || sgn_ovf);

        early_result = '0;
        if (b_zero) early_result = is_rem_op(op_in) ? in_a : '1;
        else        early_result = is_rem_op(op_in) ? '0 : in_a;

        // Divide-by-zero keeps the all-ones quotient regardless of dividend sign.
        prod_s = (sa_q ^ sb_q) ? -product : product;
        quot_s = ((sa_q ^ sb_q) && !bzero_q) ? -quotient : quotient;
        rem_s  = sa_q ? -remainder : remainder;

        final_result = rem_s;
        case (op_q)
            OP_MUL:                       final_result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_result = quot_s;
            default:                      final_result = rem_s;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = early ? DONE : CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_MUL;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            bzero_q    <= 1'b0;
            counter    <= '0;
            last_step  <= 1'b0;
            out_result <= '0;
        end else if (accept) begin
            op_q      <= op_in;
            sa_q      <= sa_in;
            sb_q      <= sb_in;
            bzero_q   <= b_zero;
            counter   <= CW'(XLEN - 1);
            last_step <= 1'b0;
            if (early) out_result <= early_result;
        end else if (dp_step) begin
            if (counter == '0) last_step <= 1'b1;
            else               counter   <= counter - 1'b1;
        end else if ((state == CALC) && last_step && !flush) begin
            out_result <= final_result;
        end
    end

    md_iter_datapath #(.XLEN(XLEN)) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (dp_step),
        .is_div    (is_div_op(op_in)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a 32-bit early-out instance and a 64-bit iterating instance.
module tb_mul_div_unit;
    import md_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [2:0]  n_in_op;
    logic [31:0] n_in_a, n_in_b, n_out_result;
    md_state_e   n_state;

    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [2:0]  w_in_op;
    logic [63:0] w_in_a, w_in_b, w_out_result;
    md_state_e   w_state;

    mul_div_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u_narrow (
        .clk(clk), .rst_n(rst_n), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_op(n_in_op), .in_a(n_in_a), .in_b(n_in_b), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .out_result(n_out_result), .state(n_state)
    );

    mul_div_unit #(.XLEN(64), .EARLY_OUT(1'b0)) u_wide (
        .clk(clk), .rst_n(rst_n), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_op(w_in_op), .in_a(w_in_a), .in_b(w_in_b), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_result(w_out_result), .state(w_state)
    );

    // scoreboard
    logic [63:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic sel_wide = 1'b0;
    logic obs_valid, obs_ready;
    logic [63:0] obs_result;

    always_comb begin
        obs_valid  = sel_wide ? w_out_valid : n_out_valid;
        obs_ready  = sel_wide ? w_in_ready : n_in_ready;
        obs_result = sel_wide ? w_out_result : {32'h0, n_out_result};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic issue(input logic wide, input md_op_e op, input logic [63:0] a, input logic [63:0] b,
                         input string tag);
        sel_wide = wide;
        #0;
        check({tag, "_in_ready"}, obs_ready, 1);
        if (wide) begin
            w_in_valid = 1'b1; w_in_op = op; w_in_a = a; w_in_b = b;
        end else begin
            n_in_valid = 1'b1; n_in_op = op; n_in_a = a[31:0]; n_in_b = b[31:0];
        end
        @(posedge clk); #1;
        n_in_valid = 1'b0; w_in_valid = 1'b0;
        n_in_a = $urandom; n_in_b = $urandom;
        w_in_a = {$urandom, $urandom}; w_in_b = {$urandom, $urandom};
    endtask

    task automatic wait_result(input int exp_lat, input string tag);
        int lat;
        logic [63:0] exp;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!obs_valid && lat < 200);
        check({tag, "_latency"}, lat, exp_lat);
        exp = exp_q.pop_front();
        check({tag, "_result"}, obs_result, exp);
    endtask

    task automatic handoff(input string tag);
        n_out_ready = 1'b1; w_out_ready = 1'b1;
        @(posedge clk); #1;
        n_out_ready = 1'b0; w_out_ready = 1'b0;
        check({tag, "_ready_after"}, obs_ready, 1);
        check({tag, "_valid_after"}, obs_valid, 0);
    endtask

    task automatic run(input logic wide, input md_op_e op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat, input string tag);
        exp_q.push_back(exp);
        issue(wide, op, a, b, tag);
        wait_result(exp_lat, tag);
        handoff(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_valid;
        n_flush = 0; n_in_valid = 0; n_in_op = 0; n_in_a = 0; n_in_b = 0; n_out_ready = 0;
        w_flush = 0; w_in_valid = 0; w_in_op = 0; w_in_a = 0; w_in_b = 0; w_out_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_n_in_ready", n_in_ready, 1);
        check("rst_n_out_valid", n_out_valid, 0);
        check("rst_n_out_result", n_out_result, 0);
        check("rst_n_state", n_state, IDLE);
        check("rst_w_in_ready", w_in_ready, 1);
        check("rst_w_out_result", w_out_result, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // multiplies: 33 cycles on the 32-bit instance
        run(0, OP_MULH,   64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33, "mulh_min");
        run(0, OP_MULHSU, 64'h8000_0000, 64'h8000_0000, 64'hC000_0000, 33, "mulhsu_min");
        run(0, OP_MULHU,  64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33, "mulhu_min");
        run(0, OP_MUL,    64'hFFFF_FFFD, 64'h5,         64'hFFFF_FFF1, 33, "mul_neg");

        // divides
        run(0, OP_DIV,  64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 33, "div_neg7_2");
        run(0, OP_REM,  64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 33, "rem_neg7_2");
        run(0, OP_DIVU, 64'h8,         64'h3, 64'h2,         33, "divu_8_3");
        run(0, OP_REMU, 64'h8,         64'h3, 64'h2,         33, "remu_8_3");

        // early-out corner cases: one cycle
        run(0, OP_DIV,  64'h5,         64'h0,         64'hFFFF_FFFF, 1, "div_by0");
        run(0, OP_REM,  64'h5,         64'h0,         64'h5,         1, "rem_by0");
        run(0, OP_DIVU, 64'hFFFF_FFF9, 64'h0,         64'hFFFF_FFFF, 1, "divu_by0");
        run(0, OP_DIV,  64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, "div_ovf");
        run(0, OP_REM,  64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         1, "rem_ovf");

        // 64-bit instance without early out: corner cases iterate, same answers
        run(1, OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE, 65, "w_mulhu_ones");
        run(1, OP_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'h5, 64'hFFFF_FFFF_FFFF_FFF1, 65, "w_mul_neg");
        run(1, OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 65, "w_div_by0");
        run(1, OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 64'hFFFF_FFFF_FFFF_FFF9, 65, "w_rem_by0");
        run(1, OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 65, "w_div_ovf");
        run(1, OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 65, "w_rem_ovf");

        // backpressure: result holds while out_ready is low
        exp_q.push_back(64'hF);
        issue(0, OP_MUL, 64'h3, 64'h5, "bp");
        wait_result(33, "bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", n_out_valid, 1);
            check("bp_hold_result", n_out_result, 32'h0000_000F);
            check("bp_hold_in_ready", n_in_ready, 0);
        end
        handoff("bp");

        // flush with in_valid in IDLE: not accepted
        n_in_valid = 1'b1; n_in_op = OP_MUL; n_in_a = 32'h2; n_in_b = 32'h2; n_flush = 1'b1;
        @(posedge clk); #1;
        n_in_valid = 1'b0; n_flush = 1'b0;
        check("flush_req_state", n_state, IDLE);
        any_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            any_valid = any_valid | n_out_valid;
        end
        check("flush_req_no_valid", any_valid, 0);

        // flush at cycle 10 of a divide
        issue(0, OP_DIV, 64'd100, 64'd7, "flush_div");
        any_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            any_valid = any_valid | n_out_valid;
        end
        n_flush = 1'b1;
        @(posedge clk); #1;
        n_flush = 1'b0;
        check("flush_in_ready", n_in_ready, 1);
        check("flush_out_valid", n_out_valid, 0);
        repeat (40) begin
            @(posedge clk); #1;
            any_valid = any_valid | n_out_valid;
        end
        check("flush_never_valid", any_valid, 0);
        run(0, OP_MUL, 64'd7, 64'd6, 64'h2A, 33, "after_flush");

        // flush together with the handoff in DONE
        exp_q.push_back(64'h4);
        issue(0, OP_MUL, 64'h2, 64'h2, "flush_done");
        wait_result(33, "flush_done");
        n_flush = 1'b1; n_out_ready = 1'b1;
        @(posedge clk); #1;
        n_flush = 1'b0; n_out_ready = 1'b0;
        check("flush_done_state", n_state, IDLE);
        check("flush_done_valid", n_out_valid, 0);

        // asynchronous reset in the middle of an operation
        issue(0, OP_DIVU, 64'd1000, 64'd10, "rst_mid");
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_state", n_state, IDLE);
        check("rst_mid_out_valid", n_out_valid, 0);
        check("rst_mid_in_ready", n_in_ready, 1);
        check("rst_mid_out_result", n_out_result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(0, OP_DIVU, 64'd1000, 64'd10, 64'd100, 33, "after_rst");

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit; successor to the single-cycle MUL/DIV paths in the ALU.
- Takes MUL/DIV/REM-class operations out of the combinational ALU so they stop limiting fmax.
- Iterative radix-2 datapath with a valid/ready handshake on both sides and a flush input for pipeline squash.
- Sits beside the ALU in EX; the hazard unit stalls on in_ready/out_valid.

Parameters:
XLEN, 32, operand/result width (32 or 64)
EARLY_OUT, 1, 1 = div-by-zero and signed overflow complete without iterating

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  abort current operation, synchronous
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request
in_op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
in_a  in  XLEN  rs1 operand
in_b  in  XLEN  rs2 operand
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_result  out  XLEN  result

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, counter=0.
- States: IDLE, CALC, DONE.
- in_ready is 1 only in IDLE.
- IDLE to CALC on in_valid && in_ready: latch op, operand magnitudes and sign flags; counter=XLEN-1.
- CALC, multiply: shift-add, one multiplier bit per cycle; 2*XLEN-bit unsigned product.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- CALC to DONE when counter==0 after the last step.
- out_valid rises XLEN+1 cycles after the accept edge, i.e. 33 cycles for XLEN=32.
- Early out (EARLY_OUT=1), divide by zero: IDLE goes directly to DONE; out_valid rises 1 cycle after accept.
  - DIV/DIVU give all-ones.
  - REM/REMU give in_a unchanged.
- Early out (EARLY_OUT=1), signed overflow (DIV/REM, a=-2^(XLEN-1), b=-1): IDLE goes directly to DONE; out_valid rises 1 cycle after accept.
  - DIV gives -2^(XLEN-1).
  - REM gives 0.
- With EARLY_OUT=0 these cases iterate, but the final results are identical.
- Sign rules:
  - MUL/MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Product is negated in 2*XLEN bits when the operand signs differ.
  - Quotient sign = sa^sb; remainder sign = sa.
- Result select: MUL gives product[XLEN-1:0]; MULH/MULHSU/MULHU give product[2XLEN-1:XLEN].
- DONE: out_valid=1 and out_result stable until the cycle with out_valid && out_ready; then IDLE.
- No new accept is allowed in the handoff cycle (in_ready=0 in DONE).
- flush in any state: next cycle is IDLE, out_valid=0, result discarded.
- flush coinciding with in_valid: the request is not accepted.
- flush coinciding with out_ready in DONE: the handoff counts, and the unit still goes to IDLE.
- rst_n asserted mid-CALC: immediate return to the reset values; no partial result is ever presented.
- Inputs are ignored outside the accept cycle; operand changes during CALC have no effect.

Decomposition:
- Shared package md_pkg holds:
  - md_op_e enum, matching funct3 encoding;
  - md_state_e enum (IDLE/CALC/DONE);
  - sign-control helper functions;
  - the constant list of ops that need signed operand a or b.
- One natural sub-module, md_iter_datapath:
  - holds the accumulator/remainder, multiplier/quotient shift registers and the per-cycle add/subtract step;
  - is controlled by the FSM in mul_div_unit.

Test Plan:
- MULH/MULHSU/MULHU on a=b=0x80000000 -> 0x40000000, 0xC0000000, 0x40000000. Each out_valid exactly 33 cycles after accept.
- DIV 0xFFFFFFF9 by 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 8 by 3 -> 2. REMU 8 by 3 -> 2.
- DIV 5 by 0 -> 0xFFFFFFFF and REM 5 by 0 -> 5. DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000, REM -> 0. With EARLY_OUT=1, all arrive 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles after MUL 3*5. Required: out_valid stays 1, out_result stays 0x0000000F, in_ready stays 0. One cycle after out_ready=1, in_ready=1.
- flush at cycle 10 of a DIV. Required: out_valid never rises, in_ready=1 next cycle, and a following MUL 7*6 returns 0x2A.
- rst_n low mid-CALC, then a re-issued op completes correctly. Also rerun with XLEN=64: MULHU of two 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
